// File: rtl/lc3b_pkg.sv
// Opcodes, FSM state encoding, condition-code bit positions and the
// sign-extension helper shared by the lc3b multi-cycle core.
package lc3b_pkg;

  localparam int LC3B_NREG = 8;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Sign-extend the low 'bits' bits of an instruction word to 16 bits.
  // Upper instruction bits are masked off, so the whole IR can be passed in.
  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    logic [15:0] hi;
    logic        sgn;
    hi  = 16'hFFFF << bits;
    sgn = |(v & (16'h0001 << (bits - 1)));
    return sgn ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/lc3b_regfile.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, cleared by the asynchronous reset.
module lc3b_regfile
  import lc3b_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = LC3B_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [2:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREG];

  // register storage: cleared on reset, written on the clock edge when we=1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3b_mc_core.sv
// Multi-cycle LC-3b core with its own control FSM and a req/ready memory port.
//
// state  | meaning
// FETCH  | read instruction at PC (first cycle after reset raises the request)
// DECODE | read register file, latch operands, form LDW/STW effective address
// EXEC   | ALU/BR/LEA complete and launch next fetch; LDW/STW launch data access
// MEM    | wait for data access; LDW writes DR and CC, then launch next fetch
// HALT   | TRAP or illegal opcode; no requests until reset
module lc3b_mc_core
  import lc3b_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                NREG     = LC3B_NREG,
  parameter logic [DATA_W-1:0] PC_RESET = 'h3000,
  parameter int                PC_INC   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [2:0]        cc_out,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] pc;
  logic [2:0]        cc;
  logic [DATA_W-1:0] a_q, b_q, ea_q;

  logic [3:0]        opcode;
  logic [2:0]        rf_raddr2;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] imm5_x, off6_x, off9_x;
  logic [DATA_W-1:0] alu_b, br_target, next_pc;
  logic [DATA_W-1:0] wb_data;
  logic              rf_we;
  logic              br_taken;
  logic              mem_done;

  function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
    logic [2:0] c;
    c = 3'b000;
    if (v[DATA_W-1])  c[CC_N] = 1'b1;
    else if (v == '0) c[CC_Z] = 1'b1;
    else              c[CC_P] = 1'b1;
    return c;
  endfunction

  assign opcode    = ir[15:12];
  // STW reads its source register through port 2 in place of SR2
  assign rf_raddr2 = (opcode == OP_STW) ? ir[11:9] : ir[2:0];
  assign imm5_x    = DATA_W'($signed(sext(ir, 5)));
  assign off6_x    = DATA_W'($signed(sext(ir, 6)));
  assign off9_x    = DATA_W'($signed(sext(ir, 9)));
  assign alu_b     = ir[5] ? imm5_x : b_q;
  assign br_target = pc + (off9_x << 1);
  assign br_taken  = |(ir[11:9] & cc);
  assign next_pc   = (opcode == OP_BR && br_taken) ? br_target : pc;
  assign mem_done  = mem_req && mem_ready;

  lc3b_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst    (reset),
    .raddr1 (ir[8:6]),
    .rdata1 (rd1),
    .raddr2 (rf_raddr2),
    .rdata2 (rd2),
    .we     (rf_we),
    .waddr  (ir[11:9]),
    .wdata  (wb_data)
  );

  // register write-back: ALU/LEA results in EXEC, load data on MEM completion
  always_comb begin
    rf_we   = 1'b0;
    wb_data = '0;
    case (state)
      ST_EXEC: begin
        case (opcode)
          OP_ADD:  begin rf_we = 1'b1; wb_data = a_q + alu_b; end
          OP_AND:  begin rf_we = 1'b1; wb_data = a_q & alu_b; end
          OP_NOT:  begin rf_we = 1'b1; wb_data = ~a_q;        end
          OP_LEA:  begin rf_we = 1'b1; wb_data = br_target;   end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (opcode == OP_LDW) begin
          rf_we   = mem_done;
          wb_data = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // control FSM with registered memory-port, PC, IR, CC and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc        <= PC_RESET;
      ir        <= '0;
      cc        <= 3'b010;
      a_q       <= '0;
      b_q       <= '0;
      ea_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir      <= mem_rdata[15:0];
            pc      <= pc + DATA_W'(PC_INC);
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q   <= rd1;
          b_q   <= rd2;
          ea_q  <= rd1 + (off6_x << 1);
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA, OP_BR: begin
              if (opcode != OP_LEA && opcode != OP_BR) cc <= cc_of(wb_data);
              pc       <= next_pc;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= next_pc;
              state    <= ST_FETCH;
            end
            OP_LDW, OP_STW: begin
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OP_STW);
              mem_addr  <= ea_q;
              mem_wdata <= b_q;
              state     <= ST_MEM;
            end
            OP_TRAP: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              illegal <= 1'b1;
              halted  <= 1'b1;
              state   <= ST_HALT;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_LDW) cc <= cc_of(wb_data);
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= ST_FETCH;
          end
        end
        default: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
          state   <= ST_HALT;
        end
      endcase
    end
  end

  assign pc_out = pc;
  assign cc_out = cc;

endmodule

// File: doc/lc3b_mc_core.md
Name: lc3b_mc_core

Overview:
- Parametrised multi-cycle LC-3b core. Successor to the externally sequenced datapath.
- Integrates its own control FSM, so no external ld*/gate* strobes are needed.
- Drives a req/ready memory handshake that tolerates arbitrary wait states.
- Sits between the top-level testbench/SoC and a single unified instruction/data memory.

Parameters:
- DATA_W, 16, datapath and register width; must be >=16; instructions use the low 16 bits of fetched data.
- NREG, 8, register-file depth; must be 8 (3-bit register fields); kept as a parameter for the package constant.
- PC_RESET, 'h3000, PC value after reset.
- PC_INC, DATA_W/8, byte increment per fetched word.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (STW), 0 = read.
- mem_addr  out  DATA_W  byte address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- mem_ready  in  1  completes the current request on this edge.
- pc_out  out  DATA_W  current PC.
- cc_out  out  3  {N,Z,P}.
- halted  out  1  core stopped (TRAP or illegal opcode).
- illegal  out  1  stopped on an unsupported opcode.

Behaviour:
- Reset (async):
  - PC=PC_RESET, IR=0, all registers 0, CC=3'b010.
  - State=FETCH, mem_req=0, halted=0, illegal=0.
- Handshake:
  - A transfer completes on the edge where mem_req&&mem_ready.
  - While waiting, mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - mem_req deasserts in the cycle after completion.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
  - FETCH: req read @PC. On completion: IR<=rdata[15:0], PC<=PC+PC_INC, go to DECODE.
  - DECODE: read the register file and form the effective address. Go to EXEC.
  - EXEC by opcode:
    - ADD(0001) / AND(0101): DR<=SR1 op (IR[5] ? sext(imm5) : SR2). Set CC. Go to FETCH.
    - NOT(1001): DR<=~SR1. Set CC. Go to FETCH.
    - BR(0000): if (IR[11:9]&{N,Z,P})!=0, PC<=PC+(sext(off9)<<1). Go to FETCH. BR with nzp=000 is a NOP.
    - LEA(1110): DR<=PC+(sext(off9)<<1). CC unchanged. Go to FETCH.
    - LDW(0110) / STW(0111): EA=BaseR+(sext(off6)<<1). Go to MEM.
    - TRAP(1111): go to HALT.
    - Any other opcode: illegal<=1, go to HALT.
  - MEM:
    - LDW: req read @EA. On completion DR<=rdata and CC is set.
    - STW: req write @EA with wdata=SR (IR[11:9]).
    - Then go to FETCH.
  - HALT: terminal. No requests. halted=1. Leaves only by reset.
- Arithmetic:
  - Modulo 2^DATA_W, no overflow flag.
  - CC: N=msb, Z=(result==0), P=otherwise; exactly one bit set.
  - PC here means the already-incremented PC.
- Latency with zero-wait memory: ALU/BR/LEA = 3 cycles; LDW/STW = 4 cycles. Each wait state adds 1 cycle.
- PC wraps modulo 2^DATA_W.
- Reset asserted mid-transfer: mem_req drops immediately (async), and the pending write is abandoned.
- Register writes and CC updates occur only in EXEC or on MEM completion, never twice per instruction.

Decomposition:
- Package lc3b_pkg:
  - Opcode localparams.
  - State encoding.
  - sext helper function.
  - CC bit indices.
- Sub-module lc3b_regfile (NREG x DATA_W): two async read ports, one sync write port, async reset.
- The FSM, ALU and EA adder stay in the core.

Test Plan:
- Reset then zero-wait memory holding ADD R1,R0,#5 (0x1225):
  - mem_addr=0x3000 on the first request.
  - After 3 cycles R1=5, cc=001, pc=0x3002.
- ADD R2,R1,#-6 with R1=5 (0x147A): R2=0xFFFF, cc=100.
  - Then BRn #2 (0x0802) fetched at 0x3002: pc becomes 0x3008.
  - BRz at the same point is not taken: pc=0x3004.
- STW R1,R0,#2 (0x7202) then LDW R3,R0,#2 (0x6602), with memory inserting 3 wait states:
  - Write to addr 4 with wdata=5, signals held stable during the waits.
  - R3=5, cc=001.
  - STW total = 4+6 cycles.
- LEA R4,#-1 (0xE9FF) at 0x3000: R4=0x3000, cc unchanged.
- TRAP (0xF025): halted=1, mem_req stays 0 for 20 cycles. Opcode 1101: illegal=1, halted=1.
- Assert reset while a write request is stalled (mem_ready=0):
  - mem_req=0 in the same cycle, pc=0x3000, cc=010.
  - The core refetches from 0x3000 after reset is released.
